// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and BCD helpers for the stopwatch.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_UNITS_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX  = 4'd5;
    localparam bcd_t MIN_DIGIT_MAX = 4'd9;

    // Maximum value of digit position idx (0 = seconds units, 1 = seconds tens).
    function automatic bcd_t digit_max(input int idx);
        if (idx == 0)
            return SEC_UNITS_MAX;
        else if (idx == 1)
            return SEC_TENS_MAX;
        else
            return MIN_DIGIT_MAX;
    endfunction

    // Successor of a digit; anything at or above max folds back to zero,
    // so an out-of-range value can never persist.
    function automatic bcd_t bcd_next(input bcd_t q, input bcd_t max);
        if (q >= max)
            return 4'd0;
        else
            return q + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit with synchronous clear, increment and carry-out.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic CLR,
    input  logic INC,
    output bcd_t Q,
    output logic CARRY
);

    // Digit register: clear wins over increment.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            Q <= 4'd0;
        else if (CLR)
            Q <= 4'd0;
        else if (INC)
            Q <= bcd_next(Q, MAX);
    end

    assign CARRY = INC && (Q == MAX);

endmodule

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch: prescaled 1 s tick, seconds/minutes digit chain,
// run/stop toggle, clear and lap (display freeze) handling.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV        = 50000000,
    parameter int          MIN_DIGITS = 2
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    START_STOP,
    input  logic                    CLEAR,
    input  logic                    LAP,
    output logic [3:0]              COUNT_1,
    output logic [3:0]              COUNT_10,
    output logic [4*MIN_DIGITS-1:0] COUNT_M,
    output logic                    RUNNING,
    output logic                    LAP_ACTIVE,
    output logic                    TICK,
    output logic                    WRAP
);

    localparam int          ND     = 2 + MIN_DIGITS;
    localparam logic [31:0] DIV_M1 = 32'(DIV - 1);

    logic              ss_q;
    logic              lap_q;
    logic              armed;
    logic              ss_rise;
    logic              lap_rise;
    logic [31:0]       pre;
    logic              tick;
    logic [ND-1:0]     inc;
    logic [ND-1:0]     carry;
    logic [ND-1:0][3:0] live;
    logic [ND-1:0][3:0] nxt;
    logic [ND-1:0][3:0] snap;
    logic [ND-1:0][3:0] disp;

    // Edge-detect history; armed stays low for the first cycle after reset so
    // a control already held high during reset is not seen as a rising edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ss_q  <= 1'b0;
            lap_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            ss_q  <= START_STOP;
            lap_q <= LAP;
            armed <= 1'b1;
        end
    end

    assign ss_rise  = armed && START_STOP && !ss_q;
    assign lap_rise = armed && LAP && !lap_q;

    // Run/stop toggle; a tick in the same cycle as a stop edge still counts
    // because the register only changes on the following edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            RUNNING <= 1'b0;
        else if (ss_rise)
            RUNNING <= !RUNNING;
    end

    // Prescaler: holds while stopped so a resumed second continues where it left off.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            pre <= 32'd0;
        else if (CLEAR)
            pre <= 32'd0;
        else if (RUNNING)
            pre <= (pre == DIV_M1) ? 32'd0 : pre + 32'd1;
    end

    assign tick = RUNNING && !CLEAR && (pre == DIV_M1);

    // Digit chain: each digit increments when all lower digits carry.
    genvar gi;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_digit
            localparam bcd_t MX = digit_max(gi);

            if (gi == 0) begin : g_first
                assign inc[gi] = tick;
            end else begin : g_rest
                assign inc[gi] = carry[gi-1];
            end

            bcd_digit #(.MAX(MX)) u_digit (
                .CLK     (CLK),
                .RESET_N (RESET_N),
                .CLR     (CLEAR),
                .INC     (inc[gi]),
                .Q       (live[gi]),
                .CARRY   (carry[gi])
            );

            // Value the digit takes on this edge, so a lap capture that
            // coincides with a tick stores the post-increment count.
            assign nxt[gi] = inc[gi] ? bcd_next(live[gi], MX) : live[gi];
        end
    endgenerate

    // Lap: first rising edge freezes a snapshot, second releases it; clear wins.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            snap       <= '0;
            LAP_ACTIVE <= 1'b0;
        end else if (CLEAR) begin
            snap       <= '0;
            LAP_ACTIVE <= 1'b0;
        end else if (lap_rise) begin
            if (LAP_ACTIVE) begin
                LAP_ACTIVE <= 1'b0;
            end else begin
                snap       <= nxt;
                LAP_ACTIVE <= 1'b1;
            end
        end
    end

    assign disp     = LAP_ACTIVE ? snap : live;
    assign COUNT_1  = disp[0];
    assign COUNT_10 = disp[1];
    assign COUNT_M  = disp[ND-1:2];
    assign TICK     = tick;
    assign WRAP     = carry[ND-1];

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed scoreboard bench for stopwatch_bcd with DIV=4, MIN_DIGITS=2.
module tb_stopwatch_bcd;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       START_STOP = 1'b0;
  logic       CLEAR = 1'b0;
  logic       LAP = 1'b0;
  logic [3:0] COUNT_1;
  logic [3:0] COUNT_10;
  logic [7:0] COUNT_M;
  logic       RUNNING;
  logic       LAP_ACTIVE;
  logic       TICK;
  logic       WRAP;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] cm;
    logic [3:0] c10;
    logic [3:0] c1;
    logic       run;
    logic       lap;
    logic       tick;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];

  stopwatch_bcd #(.DIV(4), .MIN_DIGITS(2)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START_STOP (START_STOP),
    .CLEAR      (CLEAR),
    .LAP        (LAP),
    .COUNT_1    (COUNT_1),
    .COUNT_10   (COUNT_10),
    .COUNT_M    (COUNT_M),
    .RUNNING    (RUNNING),
    .LAP_ACTIVE (LAP_ACTIVE),
    .TICK       (TICK),
    .WRAP       (WRAP)
  );

  always #5 CLK = ~CLK;

  // Monitor: on the falling edge, compare every pending expectation.
  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({COUNT_M, COUNT_10, COUNT_1, RUNNING, LAP_ACTIVE, TICK, WRAP} !==
          {e.cm, e.c10, e.c1, e.run, e.lap, e.tick, e.wrap}) begin
        errors++;
        $display("FAIL %s got %h:%h%h run=%b lap=%b tick=%b wrap=%b expected %h:%h%h run=%b lap=%b tick=%b wrap=%b",
                 e.name, COUNT_M, COUNT_10, COUNT_1, RUNNING, LAP_ACTIVE, TICK, WRAP,
                 e.cm, e.c10, e.c1, e.run, e.lap, e.tick, e.wrap);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [7:0] cm, input logic [3:0] c10,
                            input logic [3:0] c1, input logic run, input logic lap,
                            input logic tick, input logic wrap);
    exp_t e;
    e.name = name; e.cm = cm; e.c10 = c10; e.c1 = c1;
    e.run = run; e.lap = lap; e.tick = tick; e.wrap = wrap;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [7:0] cm, input logic [3:0] c10,
                           input logic [3:0] c1, input logic run, input logic lap,
                           input logic tick, input logic wrap);
    checks++;
    if ({COUNT_M, COUNT_10, COUNT_1, RUNNING, LAP_ACTIVE, TICK, WRAP} !==
        {cm, c10, c1, run, lap, tick, wrap}) begin
      errors++;
      $display("FAIL %s got %h:%h%h run=%b lap=%b tick=%b wrap=%b expected %h:%h%h run=%b lap=%b tick=%b wrap=%b",
               name, COUNT_M, COUNT_10, COUNT_1, RUNNING, LAP_ACTIVE, TICK, WRAP,
               cm, c10, c1, run, lap, tick, wrap);
    end
  endtask

  initial begin
    // Reset with START_STOP already high: release must not start the watch.
    START_STOP = 1'b1;
    cyc(3);
    check_now("reset_state_now", 8'h00, 4'd0, 4'd0, 0, 0, 0, 0);
    expect_out("reset_state", 8'h00, 4'd0, 4'd0, 0, 0, 0, 0);
    RESET_N = 1'b1;
    cyc(4);
    expect_out("no_edge_after_reset", 8'h00, 4'd0, 4'd0, 0, 0, 0, 0);
    START_STOP = 1'b0;
    cyc(1);

    // Start and run 40 cycles: tick every 4th cycle.
    START_STOP = 1'b1;
    cyc(1);
    START_STOP = 1'b0;
    for (int j = 0; j < 40; j++) begin
      expect_out("run_seq", 8'h00, 4'((j / 4) / 10), 4'((j / 4) % 10), 1, 0, (j % 4) == 3, 0);
      cyc(1);
    end
    expect_out("run40", 8'h00, 4'd1, 4'd0, 1, 0, 0, 0);

    // Stop with prescaler at 2, idle, resume: tick one cycle after resuming.
    cyc(1);
    START_STOP = 1'b1;
    cyc(1);
    START_STOP = 1'b0;
    expect_out("stopped", 8'h00, 4'd1, 4'd0, 0, 0, 0, 0);
    cyc(100);
    check_now("wait_expired_now", 8'h00, 4'd1, 4'd0, 0, 0, 0, 0);
    expect_out("still_stopped", 8'h00, 4'd1, 4'd0, 0, 0, 0, 0);
    START_STOP = 1'b1;
    cyc(1);
    START_STOP = 1'b0;
    expect_out("resume", 8'h00, 4'd1, 4'd0, 1, 0, 0, 0);
    cyc(1);
    expect_out("resume_tick", 8'h00, 4'd1, 4'd0, 1, 0, 1, 0);
    cyc(1);
    expect_out("resume_count", 8'h00, 4'd1, 4'd1, 1, 0, 0, 0);

    // Clear holds everything at zero but keeps running.
    CLEAR = 1'b1;
    cyc(1);
    expect_out("clear", 8'h00, 4'd0, 4'd0, 1, 0, 0, 0);
    cyc(4);
    expect_out("clear_hold", 8'h00, 4'd0, 4'd0, 1, 0, 0, 0);
    CLEAR = 1'b0;

    // Lap at 0:07, run 5 s, release shows 0:12.
    cyc(28);
    LAP = 1'b1;
    cyc(1);
    LAP = 1'b0;
    expect_out("lap_capture", 8'h00, 4'd0, 4'd7, 1, 1, 0, 0);
    cyc(20);
    expect_out("lap_frozen", 8'h00, 4'd0, 4'd7, 1, 1, 0, 0);
    LAP = 1'b1;
    cyc(1);
    LAP = 1'b0;
    expect_out("lap_release", 8'h00, 4'd1, 4'd2, 1, 0, 0, 0);
    cyc(1);
    LAP = 1'b1;
    cyc(1);
    LAP = 1'b0;
    expect_out("lap_on_tick", 8'h00, 4'd1, 4'd3, 1, 1, 0, 0);
    cyc(4);
    expect_out("lap_snap_hold", 8'h00, 4'd1, 4'd3, 1, 1, 0, 0);

    // Clear together with a tick and a lap edge.
    cyc(3);
    CLEAR = 1'b1;
    LAP = 1'b1;
    cyc(1);
    CLEAR = 1'b0;
    LAP = 1'b0;
    expect_out("clear_priority", 8'h00, 4'd0, 4'd0, 1, 0, 0, 0);

    // Asynchronous reset mid-second with a nonzero count.
    cyc(22);
    expect_out("pre_reset_count", 8'h00, 4'd0, 4'd5, 1, 0, 0, 0);
    cyc(1);
    RESET_N = 1'b0;
    expect_out("async_reset", 8'h00, 4'd0, 4'd0, 0, 0, 0, 0);
    cyc(2);
    RESET_N = 1'b1;
    cyc(2);
    START_STOP = 1'b1;
    cyc(1);
    START_STOP = 1'b0;
    expect_out("restart", 8'h00, 4'd0, 4'd0, 1, 0, 0, 0);
    cyc(2);
    expect_out("partial_discarded", 8'h00, 4'd0, 4'd0, 1, 0, 0, 0);
    cyc(1);
    expect_out("first_tick", 8'h00, 4'd0, 4'd0, 1, 0, 1, 0);

    // Minute carry at 0:59 and full wrap at 99:59.
    cyc(236);
    expect_out("at_0_59", 8'h00, 4'd5, 4'd9, 1, 0, 1, 0);
    cyc(1);
    expect_out("min_carry", 8'h01, 4'd0, 4'd0, 1, 0, 0, 0);
    cyc(23758);
    expect_out("at_99_59", 8'h99, 4'd5, 4'd9, 1, 0, 0, 0);
    cyc(1);
    expect_out("wrap_pulse", 8'h99, 4'd5, 4'd9, 1, 0, 1, 1);
    cyc(1);
    expect_out("wrapped", 8'h00, 4'd0, 4'd0, 1, 0, 0, 0);
    cyc(1);
    expect_out("wrap_one_cycle", 8'h00, 4'd0, 4'd0, 1, 0, 0, 0);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 Parameter DIV, default 50000000: system-clock cycles per 1 s tick; legal range 2..2^32-1.
REQ-002 Parameter MIN_DIGITS, default 2: number of BCD minute digits; legal range 1..4.
REQ-003 Port CLK  input  1  system clock; all state updates on rising edge.
REQ-004 Port RESET_N  input  1  asynchronous active-low reset.
REQ-005 Port START_STOP  input  1  synchronous level; each rising edge toggles run/stop.
REQ-006 Port CLEAR  input  1  synchronous level; while high, count and prescaler are held at zero.
REQ-007 Port LAP  input  1  synchronous level; each rising edge toggles lap (display freeze).
REQ-008 Port COUNT_1  output  4  seconds units, BCD 0-9.
REQ-009 Port COUNT_10  output  4  seconds tens, BCD 0-5.
REQ-010 Port COUNT_M  output  4*MIN_DIGITS  minutes, BCD, least-significant digit in bits [3:0].
REQ-011 Port RUNNING  output  1  high while counting is enabled.
REQ-012 Port LAP_ACTIVE  output  1  high while the display is frozen.
REQ-013 Port TICK  output  1  one-cycle pulse on each counted second.
REQ-014 Port WRAP  output  1  one-cycle pulse when the full count rolls over to all-zero.

Function
REQ-015 Edge detection: each control input is compared with its value registered on the previous cycle; a rising edge is "1 now, 0 last cycle".
REQ-016 Prescaler: a 32-bit counter advances only while RUNNING=1 and CLEAR=0; it wraps DIV-1 -> 0; TICK=1 on the cycle it equals DIV-1.
REQ-017 While stopped, the prescaler holds its value, so resume continues the partial second.
REQ-018 On a TICK cycle, the seconds-units digit increments on the same clock edge; there is no derived or gated clock.
REQ-019 Digit chain: units wrap 9->0 and carry; tens wrap 5->0 and carry; each minute digit wraps 9->0 and carries to the next minute digit.
REQ-020 A digit increments only when every lower digit is at its maximum and TICK=1.
REQ-021 At the count 9..9:5:9 a TICK sets all digits to 0 and asserts WRAP in that cycle; counting continues.
REQ-022 START_STOP rising edge toggles RUNNING, visible the next cycle; a tick coinciding with a stop edge is still counted.
REQ-023 CLEAR=1 forces all digits, the prescaler, LAP_ACTIVE and the snapshot to 0; RUNNING is unchanged.
REQ-024 CLEAR has priority over TICK, the lap edge and the digit carry.
REQ-025 LAP rising edge with LAP_ACTIVE=0: the live count is captured into the snapshot registers and LAP_ACTIVE is set.
REQ-026 LAP rising edge with LAP_ACTIVE=1: LAP_ACTIVE is cleared.
REQ-027 If a LAP capture coincides with a TICK, the snapshot holds the post-increment value.
REQ-028 COUNT_* outputs show the snapshot when LAP_ACTIVE=1, otherwise the live count; the live count keeps running during lap.
REQ-029 Digits never hold a non-BCD value or a tens value above 5.

Reset
REQ-030 RESET_N=0 asynchronously clears all digits, snapshot, prescaler, RUNNING, LAP_ACTIVE, TICK, WRAP and the edge-detect registers to 0.
REQ-031 Reset asserted mid-second discards the partial prescaler count.
REQ-032 After RESET_N deasserts, a control input already high is not treated as a rising edge.

Structure
REQ-033 Package stopwatch_pkg holds: BCD digit type (4 bits); constants SEC_UNITS_MAX=9, SEC_TENS_MAX=5, MIN_DIGIT_MAX=9.
REQ-034 Sub-module bcd_digit (parameter MAX) holds one digit with ports CLK, RESET_N, CLR, INC, Q and CARRY.
REQ-035 In bcd_digit, CARRY = INC and (Q==MAX).
REQ-036 The top level instantiates 2+MIN_DIGITS bcd_digit instances in a generate loop.

Verification
REQ-037 DIV=4, MIN_DIGITS=2: pulse START_STOP, run 40 cycles -> COUNT_1=0, COUNT_10=1, TICK pulses every 4th cycle.
REQ-038 Count 0:59 -> next TICK: COUNT_1=0, COUNT_10=0, COUNT_M=8'h01.
REQ-039 Count 99:59 -> next TICK: all outputs 0 and WRAP=1 for exactly one cycle.
REQ-040 Stop at prescaler=2, wait 100 cycles, restart -> next TICK after 1 cycle; no count lost or gained.
REQ-041 LAP at 0:07, run 5 s -> outputs show 0:07; second LAP -> outputs show 0:12.
REQ-042 CLEAR in the same cycle as TICK and a LAP edge -> all zero, LAP_ACTIVE=0; RESET_N pulsed mid-second -> all zero immediately, RUNNING=0.
